// File: rtl/jpeg_pixel_writer_if.sv
// Pixel stream and memory-write bus for jpeg_pixel_writer.
// slave  : the writer (consumes pixels, issues memory writes)
// master : the surroundings (decoder pixel port plus memory write port)
interface jpeg_pixel_writer_if;
   logic        v;
   logic [15:0] pixel_x;
   logic [15:0] pixel_y;
   logic [7:0]  pixel_r;
   logic [7:0]  pixel_g;
   logic [7:0]  pixel_b;
   logic        yumi;
   logic        wr_v;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;

   modport slave (
      input  v, pixel_x, pixel_y, pixel_r, pixel_g, pixel_b, wr_ready,
      output yumi, wr_v, wr_addr, wr_data
   );

   modport master (
      output v, pixel_x, pixel_y, pixel_r, pixel_g, pixel_b, wr_ready,
      input  yumi, wr_v, wr_addr, wr_data
   );
endinterface

// File: rtl/jpeg_pixel_writer.sv
// Decoder pixel stream -> linear framebuffer writes.
// In-bounds pixels become one memory write each through a small FIFO;
// MCU padding pixels outside width x height are counted and dropped.
// Build option JPEG_PIXEL_WRITER_RGB565_EN: 16-bit RGB565 pixels at 2 bytes
// per pixel instead of XRGB8888 at 4 bytes per pixel.
//
// state  | meaning
// IDLE   | no frame armed; pixels are not consumed
// ACTIVE | frame armed; accepting pixels until written count reaches target
module jpeg_pixel_writer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int FIFO_ADDR_W = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  frame_start_i,
   input  logic [31:0]           cfg_base_i,
   input  logic [15:0]           cfg_stride_i,
   input  logic [15:0]           img_width_i,
   input  logic [15:0]           img_height_i,
   jpeg_pixel_writer_if.slave    bus,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic [15:0]           drop_count_o
);

   typedef enum logic {IDLE, ACTIVE} state_e;

   localparam logic [FIFO_ADDR_W:0]   FULL_CNT = (FIFO_ADDR_W + 1)'(FIFO_DEPTH);
   localparam logic [FIFO_ADDR_W:0]   CNT_ONE  = (FIFO_ADDR_W + 1)'(1);
   localparam logic [FIFO_ADDR_W-1:0] PTR_ONE  = FIFO_ADDR_W'(1);

   state_e                 state_q;
   logic [31:0]            base_q;
   logic [15:0]            stride_q;
   logic [15:0]            width_q;
   logic [15:0]            height_q;
   logic [31:0]            target_q;
   logic [31:0]            written_q;
   logic [15:0]            drop_q;
   logic                   done_q;
   logic [FIFO_ADDR_W-1:0] wr_ptr_q;
   logic [FIFO_ADDR_W-1:0] rd_ptr_q;
   logic [FIFO_ADDR_W:0]   count_q;
   logic [31:0]            addr_mem_q [FIFO_DEPTH];
   logic [31:0]            data_mem_q [FIFO_DEPTH];

   logic        fifo_empty;
   logic        fifo_full;
   logic        accept;
   logic        in_bounds;
   logic        push;
   logic        pop;
   logic [31:0] target_d;
   logic [31:0] lin_idx;
   logic [31:0] pix_addr;
   logic [31:0] pix_data;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   // A full FIFO refuses the pixel even if the head pops this cycle.
   assign accept     = bus.v && (state_q == ACTIVE) && !fifo_full;
   assign in_bounds  = (bus.pixel_x < width_q) && (bus.pixel_y < height_q);
   assign push       = accept && in_bounds && !frame_start_i;
   assign pop        = !fifo_empty && bus.wr_ready;
   assign target_d   = 32'(img_width_i) * 32'(img_height_i);
   assign lin_idx    = 32'(bus.pixel_y) * 32'(stride_q) + 32'(bus.pixel_x);

`ifdef JPEG_PIXEL_WRITER_RGB565_EN
   logic unused_lsbs;
   assign unused_lsbs = ^{bus.pixel_r[2:0], bus.pixel_g[1:0], bus.pixel_b[2:0]};
   assign pix_addr = base_q + (lin_idx << 1);
   assign pix_data = {16'h0000, bus.pixel_r[7:3], bus.pixel_g[7:2], bus.pixel_b[7:3]};
`else
   assign pix_addr = base_q + (lin_idx << 2);
   assign pix_data = {8'h00, bus.pixel_r, bus.pixel_g, bus.pixel_b};
`endif

   assign bus.yumi     = accept;
   assign bus.wr_v     = !fifo_empty;
   // Head is forced to zero when empty so stale storage never shows on the bus.
   assign bus.wr_addr  = fifo_empty ? '0 : addr_mem_q[rd_ptr_q];
   assign bus.wr_data  = fifo_empty ? '0 : data_mem_q[rd_ptr_q];
   assign busy_o       = (state_q == ACTIVE);
   assign frame_done_o = done_q;
   assign drop_count_o = drop_q;

   // Frame FSM, FIFO pointers and counters; frame_start overrides push/pop.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         base_q    <= '0;
         stride_q  <= '0;
         width_q   <= '0;
         height_q  <= '0;
         target_q  <= '0;
         written_q <= '0;
         drop_q    <= '0;
         done_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else if (frame_start_i) begin
         state_q   <= ACTIVE;
         base_q    <= cfg_base_i;
         stride_q  <= cfg_stride_i;
         width_q   <= img_width_i;
         height_q  <= img_height_i;
         target_q  <= target_d;
         written_q <= '0;
         drop_q    <= '0;
         // An empty frame completes immediately: pulse in the next cycle.
         done_q    <= (target_d == '0);
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            written_q <= written_q + 32'd1;
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_q <= count_q - CNT_ONE;
         end
         if (accept && !in_bounds && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
         end
         if (state_q == ACTIVE) begin
            if (target_q == '0) begin
               state_q <= IDLE;
            end else if (pop && ((written_q + 32'd1) == target_q)) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
         end
      end
   end

   // FIFO storage; contents need no reset because count_q gates visibility.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push) begin
         addr_mem_q[wr_ptr_q] <= pix_addr;
         data_mem_q[wr_ptr_q] <= pix_data;
      end
   end

endmodule
